// File: rtl/mem_responder.sv
// mem_responder: wait-state memory responder with byte/half/word load/store and error reporting
module mem_responder #(
  parameter int DEPTH = 256,
  parameter int WAIT_CYCLES = 1
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        Req,
  input  logic        Wr,
  input  logic [1:0]  Size,
  input  logic        Signed,
  input  logic [31:0] Address,
  input  logic [31:0] DataIn,
  output logic        Ready,
  output logic [31:0] DataOut,
  output logic        Error,
  output logic        Busy
);
  localparam int AW = $clog2(DEPTH);
  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;
  state_t state;
  logic [3:0] cnt;
  logic wr_q, sg_q;
  logic [1:0] sz_q;
  logic [31:0] a_q, d_q;
  logic [31:0] mem [DEPTH];
  logic idle, go, err, e_wr, e_sg;
  logic [1:0] e_sz;
  logic [31:0] e_a, e_d, rd, ld, wd;
  logic [15:0] sh;
  logic [3:0] be;
  logic [AW-1:0] idx;
  assign idle = state == IDLE;
  assign Busy = !idle;
  // with zero wait states the commit edge is the accept edge, so use the live inputs
  assign e_wr = idle ? Wr : wr_q;
  assign e_sg = idle ? Signed : sg_q;
  assign e_sz = idle ? Size : sz_q;
  assign e_a  = idle ? Address : a_q;
  assign e_d  = idle ? DataIn : d_q;
  assign go = idle ? Req && WAIT_CYCLES == 0 : state == WAIT && cnt == 4'(WAIT_CYCLES - 1);
  assign err = e_sz == 2'b11 || (e_sz == 2'b01 && e_a[0]) || (e_sz == 2'b10 && e_a[1:0] != 2'b00)
               || e_a >= 32'(4 * DEPTH);
  assign idx = e_a[AW+1:2];
  assign rd = mem[idx];
  assign sh = 16'(rd >> {e_a[1:0], 3'b000});
  assign ld = e_sz == 2'b00 ? {{24{e_sg & sh[7]}}, sh[7:0]} :
              e_sz == 2'b01 ? {{16{e_sg & sh[15]}}, sh} : rd;
  assign wd = e_sz == 2'b00 ? {4{e_d[7:0]}} : e_sz == 2'b01 ? {2{e_d[15:0]}} : e_d;
  assign be = e_sz == 2'b00 ? 4'b0001 << e_a[1:0] : e_sz == 2'b01 ? 4'b0011 << {e_a[1], 1'b0} : 4'b1111;
  always_ff @(posedge Clk) begin
    if (!Reset && go && e_wr && !err)
      for (int i = 0; i < 4; i++)
        if (be[i]) mem[idx][8*i +: 8] <= wd[8*i +: 8];
  end
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state <= IDLE;
      cnt <= 4'd0;
      Ready <= 1'b0;
      Error <= 1'b0;
      DataOut <= 32'd0;
    end else begin
      Ready <= go;
      Error <= go && err;
      DataOut <= go && !e_wr && !err ? ld : 32'd0;
      case (state)
        IDLE: if (Req) begin
          wr_q <= Wr;
          sz_q <= Size;
          sg_q <= Signed;
          a_q <= Address;
          d_q <= DataIn;
          cnt <= 4'd0;
          state <= WAIT_CYCLES == 0 ? RESP : WAIT;
        end
        WAIT: if (cnt == 4'(WAIT_CYCLES - 1)) state <= RESP;
              else cnt <= cnt + 4'd1;
        default: state <= IDLE;
      endcase
    end
  end
endmodule
